// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Counter width for an iteration count of w; never narrower than one bit.
    function automatic int clog2(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a generated full-adder chain.
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: magnitudes multiplied over WIDTH
// cycles, sign applied in a final FIX cycle.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int                 CW       = clog2(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_b, add_sum;
    logic                 add_co;
    logic [2*WIDTH-1:0]   full;

    assign add_b = mplier_q[0] ? mcand_q : '0;
    assign full  = {acc_q, mplier_q};

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_co)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Most-negative operand negates to itself, which is its correct unsigned magnitude.
                    mcand_d  = (signed_mode & a[WIDTH-1]) ? (~a + ONE_W) : a;
                    mplier_d = (signed_mode & b[WIDTH-1]) ? (~b + ONE_W) : b;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = {add_co, add_sum[WIDTH-1:1]};
                mplier_d = {add_sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                product_d = neg_q ? (~full + ONE_2W) : full;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int failures = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    // Launch one operation; report done cycle index (cycle after T0 = 1),
    // busy cycle count, and whether product moved or busy/done overlapped early.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sm,
                          output int lat, output int busy_cyc, output logic early_chg,
                          output logic overlap);
        logic [2*W-1:0] prev;
        @(negedge clk);
        prev = product;
        a = ia; b = ib; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = $urandom; b = $urandom; signed_mode = $urandom;
        lat = -1; busy_cyc = 0; early_chg = 1'b0; overlap = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (busy && done) overlap = 1'b1;
            if (done) begin lat = i; break; end
            if (product !== prev) early_chg = 1'b1;
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic sm, input logic [2*W-1:0] exp);
        int lat, bc;
        logic ec, ov;
        run_op(ia, ib, sm, lat, bc, ec, ov);
        checks++;
        if (product !== exp) begin
            failures++;
            $display("FAIL %s product got=%h exp=%h", name, product, exp);
        end
        checks++;
        if (lat != 10) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=10", name, lat);
        end
        checks++;
        if (bc != 9 || ec || ov) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=9 early_change=%0b overlap=%0b", name, bc, ec, ov);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b product=%h exp 0/0/0000", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        check_op("u_13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
        check_op("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        check_op("u_0xa5", 8'h00, 8'hA5, 1'b0, 16'h0000);
        check_op("u_fdx07", 8'hFD, 8'h07, 1'b0, 16'h06EB);
        check_op("u_1x80", 8'h01, 8'h80, 1'b0, 16'h0080);
    endtask

    task automatic test_signed();
        check_op("s_m3x7", 8'hFD, 8'h07, 1'b1, 16'hFFEB);
        check_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        check_op("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        check_op("s_5xm1", 8'h05, 8'hFF, 1'b1, 16'hFFFB);
        check_op("s_0xm7", 8'h00, 8'hF9, 1'b1, 16'h0000);
    endtask

    task automatic test_handshake();
        int lat;
        logic held;
        @(negedge clk);
        a = 8'd6; b = 8'd7; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin a = 8'd1; b = 8'd1; start = 1'b1; end
            else if (!done) start = 1'b0;
            if (done) begin lat = i; break; end
        end
        checks++;
        if (product !== 16'd42 || lat != 10) begin
            failures++;
            $display("FAIL hs_ignore product got=%0d exp=42 done_cycle got=%0d exp=10", product, lat);
        end
        // Still in the done cycle: request the next operation.
        a = 8'd2; b = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; held = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
            if (product !== 16'd42 || !busy) held = 1'b0;
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL hs_hold product/busy not held before second done, product=%0d", product);
        end
        checks++;
        if (product !== 16'd6 || lat != 10) begin
            failures++;
            $display("FAIL hs_b2b product got=%0d exp=6 done_cycle got=%0d exp=10", product, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic stray;
        @(negedge clk);
        a = 8'd100; b = 8'd100; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("FAIL rst_mid busy=%b done=%b product=%h exp 0/0/0000", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL rst_stray busy/done seen after aborted op got=1 exp=0");
        end
        check_op("rst_6x7", 8'd6, 8'd7, 1'b0, 16'd42);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
